// File: rtl/renorm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : renorm_pkg
//  Brief    : Shared binary64 field widths, rounding-mode encodings and the
//             helper that assembles a positive double from exponent/mantissa.
//  Revision : 1.0 - initial release
// ============================================================================
package renorm_pkg;

   localparam int DP_EXP_W = 11;
   localparam int DP_MAN_W = 52;
   localparam int DP_W     = 64;

   localparam logic RND_TRUNC = 1'b0;
   localparam logic RND_RNE   = 1'b1;

   // Sign is always zero: this path only ever produces non-negative values.
   function automatic logic [DP_W-1:0] pack_dp(input logic [DP_EXP_W-1:0] exp_i,
                                               input logic [DP_MAN_W-1:0] man_i);
      return {1'b0, exp_i, man_i};
   endfunction

endpackage
`default_nettype wire

// File: rtl/renorm_lzc.sv
`default_nettype none
// ============================================================================
//  Module   : renorm_lzc
//  Brief    : Combinational leading-zero counter with all-zero flag, built as
//             a binary reduction tree over the input padded to a power of two.
//  Revision : 1.0 - initial release
// ============================================================================
module renorm_lzc #(
   parameter int W = 96
) (
   input  logic [W-1:0]         data_i,
   output logic [$clog2(W)-1:0] cnt_o,
   output logic                 zero_o
);

   localparam int CW = $clog2(W);
   localparam int P  = 1 << CW;

   logic [P-1:0]  pad;
   logic [P-1:0]  lvl_v [CW+1];
   logic [CW-1:0] lvl_c [CW+1][P];

   // Zero padding below the LSB leaves the count of any non-zero input intact.
   generate
      if (P == W) begin : g_nopad
         assign pad = data_i;
      end else begin : g_pad
         assign pad = {data_i, {(P-W){1'b0}}};
      end
   endgenerate

   // Each node merges its two children: hi child wins if it holds a one,
   // otherwise the count is the hi span width plus the lo child's count.
   always_comb begin
      for (int l = 0; l <= CW; l++) begin
         lvl_v[l] = '0;
         for (int j = 0; j < P; j++) begin
            lvl_c[l][j] = '0;
         end
      end
      lvl_v[0] = pad;
      for (int l = 1; l <= CW; l++) begin
         for (int j = 0; j < (P >> l); j++) begin
            lvl_v[l][j] = lvl_v[l-1][2*j+1] | lvl_v[l-1][2*j];
            lvl_c[l][j] = lvl_v[l-1][2*j+1] ? lvl_c[l-1][2*j+1]
                                            : (lvl_c[l-1][2*j] | (CW'(1) << (l-1)));
         end
      end
   end

   assign cnt_o  = lvl_c[CW][0];
   assign zero_o = ~lvl_v[CW][0];

endmodule
`default_nettype wire

// File: rtl/renorm_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : renorm_pipe
//  Brief    : 3-stage unsigned fixed-point to binary64 normaliser with
//             truncate/RNE rounding, zero/underflow flags, valid/ready
//             handshake and pass-through tag.
//  Revision : 1.0 - initial release
// ============================================================================
module renorm_pipe
   import renorm_pkg::*;
#(
   parameter int IN_W     = 96,
   parameter int EXP_BASE = 1013,
   parameter int TAG_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             rnd_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DP_W-1:0]  out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero,
   output logic             out_uflow
);

   localparam int KW = $clog2(IN_W);
   localparam int EW = 13;
   localparam int XW = IN_W + DP_MAN_W + 1;
   localparam logic signed [EW-1:0] c_exp_one = EW'(1);

   generate
      if (IN_W < 53 || IN_W > 128) begin : g_bad_in_w
         $error("renorm_pipe: IN_W must be in 53..128");
      end
      if (EXP_BASE < 1 || EXP_BASE > 2045) begin : g_bad_exp_base
         $error("renorm_pipe: EXP_BASE must be in 1..2045");
      end
   endgenerate

   // Whole pipe advances together; a stall freezes bubbles too.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // ---------------- Stage 1 ----------------
   logic [KW-1:0]    lzc_cnt;
   logic             lzc_zero;
   logic             v1_q, mode1_q, z1_q;
   logic [IN_W-1:0]  data1_q;
   logic [TAG_W-1:0] tag1_q;
   logic [KW-1:0]    k1_q;

   renorm_lzc #(.W(IN_W)) u_lzc (
      .data_i (in_data),
      .cnt_o  (lzc_cnt),
      .zero_o (lzc_zero)
   );

   // Capture input sample together with its leading-zero count.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         mode1_q <= 1'b0;
         z1_q    <= 1'b0;
         data1_q <= '0;
         tag1_q  <= '0;
         k1_q    <= '0;
      end else if (en) begin
         v1_q    <= in_valid;
         mode1_q <= rnd_mode;
         z1_q    <= lzc_zero;
         data1_q <= in_data;
         tag1_q  <= in_tag;
         k1_q    <= lzc_cnt;
      end
   end

   // ---------------- Stage 2 ----------------
   logic [KW:0]            shamt;
   logic [IN_W-1:0]        shifted;
   logic [XW-1:0]          ext;
   logic signed [EW-1:0]   exp_s;
   logic [DP_MAN_W-1:0]    man2_d;
   logic                   guard2_d, sticky2_d, uf2_d;

   // Shifting by k+1 drops the implicit leading one off the top; the zero
   // tail lets narrow inputs (IN_W=53) still yield a guard bit and zero-fill.
   always_comb begin
      shamt     = (KW+1)'(k1_q) + (KW+1)'(1);
      shifted   = data1_q << shamt;
      ext       = {shifted, {(DP_MAN_W+1){1'b0}}};
      man2_d    = ext[XW-1 -: DP_MAN_W];
      guard2_d  = ext[IN_W];
      sticky2_d = |ext[IN_W-1:0];
      exp_s     = EW'(EXP_BASE) - EW'(k1_q);
      uf2_d     = !z1_q && (exp_s < c_exp_one);
   end

   logic                v2_q, mode2_q, z2_q, uf2_q, guard2_q, sticky2_q;
   logic [TAG_W-1:0]    tag2_q;
   logic [DP_MAN_W-1:0] man2_q;
   logic [DP_EXP_W-1:0] exp2_q;

   // Stage 2 register: unrounded mantissa, rounding bits and exponent.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_q      <= 1'b0;
         mode2_q   <= 1'b0;
         z2_q      <= 1'b0;
         uf2_q     <= 1'b0;
         guard2_q  <= 1'b0;
         sticky2_q <= 1'b0;
         tag2_q    <= '0;
         man2_q    <= '0;
         exp2_q    <= '0;
      end else if (en) begin
         v2_q      <= v1_q;
         mode2_q   <= mode1_q;
         z2_q      <= z1_q;
         uf2_q     <= uf2_d;
         guard2_q  <= guard2_d;
         sticky2_q <= sticky2_d;
         tag2_q    <= tag1_q;
         man2_q    <= man2_d;
         exp2_q    <= exp_s[DP_EXP_W-1:0];
      end
   end

   // ---------------- Stage 3 ----------------
   logic                inc;
   logic [DP_MAN_W:0]   man_sum;
   logic [DP_EXP_W-1:0] exp_r;
   logic [DP_W-1:0]     data3_d;

   // Round-to-nearest-even; a mantissa carry wraps it to zero and bumps exp.
   always_comb begin
      inc     = (mode2_q == RND_RNE) && guard2_q && (sticky2_q || man2_q[0]);
      man_sum = {1'b0, man2_q} + {{DP_MAN_W{1'b0}}, inc};
      exp_r   = exp2_q + {{(DP_EXP_W-1){1'b0}}, man_sum[DP_MAN_W]};
      data3_d = pack_dp(exp_r, man_sum[DP_MAN_W-1:0]);
      if (z2_q || uf2_q) begin
         data3_d = '0;
      end
   end

   logic             out_valid_q, out_zero_q, out_uflow_q;
   logic [DP_W-1:0]  out_data_q;
   logic [TAG_W-1:0] out_tag_q;

   // Output register: held stable whenever downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_zero_q  <= 1'b0;
         out_uflow_q <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
      end else if (en) begin
         out_valid_q <= v2_q;
         out_zero_q  <= z2_q;
         out_uflow_q <= uf2_q;
         out_data_q  <= data3_d;
         out_tag_q   <= tag2_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_zero  = out_zero_q;
   assign out_uflow = out_uflow_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;

endmodule
`default_nettype wire
